noc_router: RTL and testbench
=============================

NOC_ROUTER -- requirements
Module: noc_router

Interface
REQ-001 Parameter DATA_W, default 16, flit width in bits.
REQ-002 Parameter FIFO_DEPTH, default 4, entries per input FIFO; a power of 2, at least 2.
REQ-003 Port clk  in  1  rising-edge clock.
REQ-004 Port reset  in  1  reset; asynchronous, active-high.
REQ-005 Ports writeE, writeW, writeL  in  1 each  per-input write strobes for East, West, Local.
REQ-006 Ports dataInE, dataInW, dataInL  in  DATA_W each  per-input write flits.
REQ-007 Ports dataOutE, dataOutW, dataOutL  out  DATA_W each  registered output flits.
REQ-008 Ports fullE, almost_fullE, fullW, almost_fullW, fullL, almost_fullL  out  1 each  input FIFO status.
REQ-009 Port order SHALL be: clk, reset, the three writes, the three dataIns, the three dataOuts, then full/almost_full pairs in E, W, L order.

Function
REQ-010 Flit format SHALL be: bit0 = valid; bits[2:1] = destination; bits[4:3] = source id; bits[DATA_W-1:5] = payload.
REQ-011 Port encoding for destination and source SHALL be: 00 = East, 01 = West, 10 = Local, 11 = invalid.
REQ-012 Each input SHALL own a FIFO_DEPTH-entry FIFO that enqueues dataIn on a rising edge where write=1 and full=0.
REQ-013 A write while full SHALL be dropped silently, with no state change.
REQ-014 full SHALL be 1 iff occupancy == FIFO_DEPTH.
REQ-015 almost_full SHALL be 1 iff occupancy >= FIFO_DEPTH-1.
REQ-016 Both status flags SHALL be combinational from the registered occupancy.
REQ-017 Each cycle, every non-empty FIFO SHALL request exactly one output, the one named by its head flit's destination field.
REQ-018 Each output SHALL have an independent round-robin arbiter over inputs E, W, L.
REQ-019 The round-robin pointer SHALL advance to the input after the last granted one; after reset the starting priority is E, then W, then L.
REQ-020 A granted head SHALL be popped, and its flit SHALL be driven unmodified on that output's dataOut register at the same edge.
REQ-021 An output with no grant SHALL register all-zero, so valid=0.
REQ-022 Outputs SHALL have no backpressure; every grant completes in one cycle.
REQ-023 A head with destination 11 SHALL be popped and discarded without driving any output.
REQ-024 A head with valid=0 SHALL be routed like any other flit.
REQ-025 Routing back to a flit's own input port (U-turn) SHALL be allowed.
REQ-026 Latency: a flit written at edge t into an empty FIFO with an uncontested output SHALL appear on dataOut after edge t+1.
REQ-027 Simultaneous write and pop on the same FIFO in one cycle SHALL both take effect, leaving occupancy unchanged; a write while full is dropped even if a pop occurs the same edge.
REQ-028 Throughput: each output SHALL deliver up to one flit per cycle, and each input SHALL drain up to one flit per cycle.

Reset
REQ-029 Reset SHALL empty all FIFOs, so full=0 and almost_full=0.
REQ-030 Reset SHALL clear all dataOut registers to 0.
REQ-031 Reset SHALL return all round-robin pointers to E priority.
REQ-032 Reset asserted mid-operation SHALL discard all queued flits immediately.

Structure
REQ-033 A shared package noc_pkg SHALL hold: DATA_W; the port encodings PORT_E, PORT_W, PORT_L, PORT_INV; and the flit field bit positions.
REQ-034 The FIFO SHALL be one sub-module, noc_fifo, instantiated three times; arbitration and output registers SHALL be inline in noc_router.

Verification
REQ-035 Scenario: after reset, write E flit 0x0023 (dest W) once -> dataOutW = 0x0023 one edge later, then 0; dataOutE = dataOutL = 0.
REQ-036 Scenario: E and L continuously write to W (id 00 and 10, payload counting up) -> dataOutW alternates E, L, E, L with no idle cycles; payloads per source stay in order.
REQ-037 Scenario: write E every cycle with W output saturated by L -> almost_fullE rises at occupancy 3 and fullE at 4; a write while full is dropped and never appears on an output.
REQ-038 Scenario: E writes to W while L writes to E in the same cycles -> both outputs are valid each cycle with no interference.
REQ-039 Scenario: flit with destination 11 -> FIFO drains and no output goes valid.
REQ-040 Scenario: assert reset with 3 flits queued -> flags clear and all dataOut = 0 immediately; no queued flit is emitted afterward.

Source files
------------

// File: rtl/noc_pkg.sv
// Shared definitions for the 3-port mesh router: flit field layout, port codes
// and the modulo-3 round-robin helper.
package noc_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned NUM_PORTS = 3;

  localparam logic [1:0] PORT_E = 2'b00;
  localparam logic [1:0] PORT_W = 2'b01;
  localparam logic [1:0] PORT_L = 2'b10;
  localparam logic [1:0] PORT_INV = 2'b11;

  localparam int unsigned VALID_BIT = 0;
  localparam int unsigned DEST_LSB = 1;
  localparam int unsigned DEST_MSB = 2;
  localparam int unsigned SRC_LSB = 3;
  localparam int unsigned SRC_MSB = 4;
  localparam int unsigned PAYLOAD_LSB = 5;

  // (base + offset) mod 3, with base and offset each in 0..2
  function automatic logic [1:0] rr_add(input logic [1:0] base, input logic [1:0] offset);
    logic [2:0] sum;
    logic [2:0] wrapped;
    sum = {1'b0, base} + {1'b0, offset};
    wrapped = sum - 3'd3;
    return (sum >= 3'd3) ? wrapped[1:0] : sum[1:0];
  endfunction

endpackage

// File: rtl/noc_fifo.sv
// Per-input flit FIFO with first-word-fall-through head and occupancy flags.
module noc_fifo #(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] head_o,
  output logic              empty_o,
  output logic              full_o,
  output logic              almost_full_o
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [DATA_W-1:0] mem_d [FIFO_DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]   count_q, count_d;
  logic              push;
  logic              pop;

  assign full_o        = (count_q == CntW'(FIFO_DEPTH));
  assign almost_full_o = (count_q >= CntW'(FIFO_DEPTH - 1));
  assign empty_o       = (count_q == '0);
  assign head_o        = mem_q[rd_ptr_q];

  // A write while full is dropped even when a pop frees a slot on the same edge
  assign push = wr_i & ~full_o;
  assign pop  = pop_i & ~empty_o;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = wdata_i;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    count_d = count_q + CntW'(push) - CntW'(pop);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/noc_router.sv
// Three-port (E, W, L) router: input FIFOs, per-output round-robin arbitration
// and registered output flits with no backpressure.
module noc_router #(
  parameter int unsigned DATA_W     = noc_pkg::DATA_W,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              writeE,
  input  logic              writeW,
  input  logic              writeL,
  input  logic [DATA_W-1:0] dataInE,
  input  logic [DATA_W-1:0] dataInW,
  input  logic [DATA_W-1:0] dataInL,
  output logic [DATA_W-1:0] dataOutE,
  output logic [DATA_W-1:0] dataOutW,
  output logic [DATA_W-1:0] dataOutL,
  output logic              fullE,
  output logic              almost_fullE,
  output logic              fullW,
  output logic              almost_fullW,
  output logic              fullL,
  output logic              almost_fullL
);
  import noc_pkg::*;

  logic [NUM_PORTS-1:0] wr;
  logic [NUM_PORTS-1:0] empty;
  logic [NUM_PORTS-1:0] full;
  logic [NUM_PORTS-1:0] almost_full;
  logic [NUM_PORTS-1:0] pop;
  logic [DATA_W-1:0]    din   [NUM_PORTS];
  logic [DATA_W-1:0]    head  [NUM_PORTS];
  logic [DATA_W-1:0]    out_q [NUM_PORTS];
  logic [DATA_W-1:0]    out_d [NUM_PORTS];
  // Highest-priority input for each output
  logic [1:0]           ptr_q [NUM_PORTS];
  logic [1:0]           ptr_d [NUM_PORTS];
  logic                 granted;
  logic [1:0]           cand;

  assign wr     = {writeL, writeW, writeE};
  assign din[0] = dataInE;
  assign din[1] = dataInW;
  assign din[2] = dataInL;

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_fifo
    noc_fifo #(
      .DATA_W    (DATA_W),
      .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo (
      .clk          (clk),
      .reset        (reset),
      .wr_i         (wr[i]),
      .wdata_i      (din[i]),
      .pop_i        (pop[i]),
      .head_o       (head[i]),
      .empty_o      (empty[i]),
      .full_o       (full[i]),
      .almost_full_o(almost_full[i])
    );
  end

  always_comb begin
    pop     = '0;
    granted = 1'b0;
    cand    = '0;
    for (int o = 0; o < NUM_PORTS; o++) begin
      out_d[o] = '0;
      ptr_d[o] = ptr_q[o];
    end
    // Heads addressed to the invalid port are discarded without touching any output
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (!empty[i] && head[i][DEST_MSB:DEST_LSB] == PORT_INV) begin
        pop[i] = 1'b1;
      end
    end
    for (int o = 0; o < NUM_PORTS; o++) begin
      granted = 1'b0;
      for (int k = 0; k < NUM_PORTS; k++) begin
        cand = rr_add(ptr_q[o], 2'(k));
        if (!granted && !empty[cand] && head[cand][DEST_MSB:DEST_LSB] == 2'(o)) begin
          granted    = 1'b1;
          pop[cand]  = 1'b1;
          out_d[o]   = head[cand];
          ptr_d[o]   = rr_add(cand, 2'd1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_q <= '{default: '0};
      ptr_q <= '{default: PORT_E};
    end else begin
      out_q <= out_d;
      ptr_q <= ptr_d;
    end
  end

  assign dataOutE     = out_q[0];
  assign dataOutW     = out_q[1];
  assign dataOutL     = out_q[2];
  assign fullE        = full[0];
  assign almost_fullE = almost_full[0];
  assign fullW        = full[1];
  assign almost_fullW = almost_full[1];
  assign fullL        = full[2];
  assign almost_fullL = almost_full[2];

endmodule

// File: tb/tb_noc_router.sv
// Self-checking bench for noc_router: hand-derived vector table, directed
// corner sequences and random traffic against a queue-based reference model.
module tb_noc_router;

  localparam int unsigned DW    = 16;
  localparam int unsigned DEPTH = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          writeE = 1'b0, writeW = 1'b0, writeL = 1'b0;
  logic [DW-1:0] dataInE = '0, dataInW = '0, dataInL = '0;
  logic [DW-1:0] dataOutE, dataOutW, dataOutL;
  logic          fullE, almost_fullE, fullW, almost_fullW, fullL, almost_fullL;

  always #5 clk = ~clk;

  noc_router #(
    .DATA_W    (DW),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .writeE      (writeE),
    .writeW      (writeW),
    .writeL      (writeL),
    .dataInE     (dataInE),
    .dataInW     (dataInW),
    .dataInL     (dataInL),
    .dataOutE    (dataOutE),
    .dataOutW    (dataOutW),
    .dataOutL    (dataOutL),
    .fullE       (fullE),
    .almost_fullE(almost_fullE),
    .fullW       (fullW),
    .almost_fullW(almost_fullW),
    .fullL       (fullL),
    .almost_fullL(almost_fullL)
  );

  logic [DW-1:0] dout [3];
  logic [2:0]    dfull, daf;
  assign dout[0] = dataOutE;
  assign dout[1] = dataOutW;
  assign dout[2] = dataOutL;
  assign dfull   = {fullL, fullW, fullE};
  assign daf     = {almost_fullL, almost_fullW, almost_fullE};

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: one queue per input, last-granted input per output
  logic [DW-1:0] mq [3][$];
  int            last_g [3];
  logic [DW-1:0] exp_out [3];
  bit            last_drop [3];

  typedef struct {
    logic [2:0]    w;
    logic [DW-1:0] de, dw, dl;
    logic [DW-1:0] oe, ow, ol;
  } vec_t;
  vec_t tbl [$];

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] mk(input int dest, input int src, input int payload,
                                       input bit valid);
    logic [DW-1:0] f;
    f       = '0;
    f[0]    = valid;
    f[2:1]  = dest[1:0];
    f[4:3]  = src[1:0];
    f[DW-1:5] = payload[DW-6:0];
    return f;
  endfunction

  task automatic model_reset();
    for (int p = 0; p < 3; p++) begin
      mq[p].delete();
      last_g[p]  = 2;
      exp_out[p] = '0;
    end
  endtask

  task automatic model_edge(input logic [2:0] w, input logic [DW-1:0] de, dw, dl);
    logic [DW-1:0] d [3];
    logic [DW-1:0] h;
    bit            pre_full [3];
    bit            take [3];
    bit            found;
    int            i;
    d[0] = de; d[1] = dw; d[2] = dl;
    for (int p = 0; p < 3; p++) begin
      pre_full[p] = (mq[p].size() >= DEPTH);
      take[p]     = 1'b0;
    end
    for (int o = 0; o < 3; o++) begin
      exp_out[o] = '0;
      found      = 1'b0;
      for (int k = 1; k <= 3; k++) begin
        i = (last_g[o] + k) % 3;
        if (!found && mq[i].size() > 0) begin
          h = mq[i][0];
          if (int'(h[2:1]) == o) begin
            found      = 1'b1;
            exp_out[o] = h;
            last_g[o]  = i;
            take[i]    = 1'b1;
          end
        end
      end
    end
    for (int p = 0; p < 3; p++) begin
      if (mq[p].size() > 0) begin
        h = mq[p][0];
        if (h[2:1] == 2'b11) take[p] = 1'b1;
      end
    end
    for (int p = 0; p < 3; p++) begin
      if (take[p]) void'(mq[p].pop_front());
      last_drop[p] = w[p] && pre_full[p];
      if (w[p] && !pre_full[p]) mq[p].push_back(d[p]);
    end
  endtask

  // Apply inputs across one rising edge, then compare every output and flag
  task automatic step(input logic [2:0] w, input logic [DW-1:0] de, dw, dl);
    writeE  = w[0]; writeW  = w[1]; writeL  = w[2];
    dataInE = de;   dataInW = dw;   dataInL = dl;
    @(posedge clk);
    model_edge(w, de, dw, dl);
    #1;
    for (int o = 0; o < 3; o++) check($sformatf("dataOut[%0d]", o), dout[o], exp_out[o]);
    for (int p = 0; p < 3; p++) begin
      check($sformatf("full[%0d]", p), DW'(dfull[p]), DW'(mq[p].size() == DEPTH));
      check($sformatf("almost_full[%0d]", p), DW'(daf[p]), DW'(mq[p].size() >= DEPTH - 1));
    end
  endtask

  task automatic reset_dut();
    writeE = 1'b0; writeW = 1'b0; writeL = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic add_vec(input logic [2:0] w, input logic [DW-1:0] de, dw, dl, oe, ow, ol);
    vec_t v;
    v.w = w; v.de = de; v.dw = dw; v.dl = dl; v.oe = oe; v.ow = ow; v.ol = ol;
    tbl.push_back(v);
  endtask

  initial begin
    int            exp_pay [4];
    logic [DW-1:0] fw;
    int            prev_src;
    int            af_cyc, full_cyc;
    bit            dropped [16];
    int            dropped_seen;
    logic [DW-1:0] r [3];
    logic [2:0]    rw;

    model_reset();
    #1 reset = 1'b1;
    #1;
    for (int o = 0; o < 3; o++) check($sformatf("reset dataOut[%0d]", o), dout[o], '0);
    check("reset full", DW'(dfull), '0);
    check("reset almost_full", DW'(daf), '0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Hand-derived vectors, starting from the post-reset state
    add_vec(3'b001, 16'h0023, '0, '0, '0, '0, '0);
    add_vec(3'b000, '0, '0, '0, '0, 16'h0023, '0);
    add_vec(3'b000, '0, '0, '0, '0, '0, '0);
    add_vec(3'b101, 16'h0023, '0, 16'h0011, '0, '0, '0);
    add_vec(3'b101, 16'h0043, '0, 16'h0031, 16'h0011, 16'h0023, '0);
    add_vec(3'b000, '0, '0, '0, 16'h0031, 16'h0043, '0);
    add_vec(3'b000, '0, '0, '0, '0, '0, '0);
    add_vec(3'b001, 16'h0007, '0, '0, '0, '0, '0);
    add_vec(3'b000, '0, '0, '0, '0, '0, '0);
    add_vec(3'b010, '0, 16'h000B, '0, '0, '0, '0);
    add_vec(3'b000, '0, '0, '0, '0, 16'h000B, '0);
    add_vec(3'b001, 16'h0022, '0, '0, '0, '0, '0);
    add_vec(3'b000, '0, '0, '0, '0, 16'h0022, '0);
    add_vec(3'b100, '0, '0, 16'h0015, '0, '0, '0);
    add_vec(3'b000, '0, '0, '0, '0, '0, 16'h0015);
    add_vec(3'b000, '0, '0, '0, '0, '0, '0);
    for (int v = 0; v < tbl.size(); v++) begin
      step(tbl[v].w, tbl[v].de, tbl[v].dw, tbl[v].dl);
      check($sformatf("vec%0d dataOutE", v), dataOutE, tbl[v].oe);
      check($sformatf("vec%0d dataOutW", v), dataOutW, tbl[v].ow);
      check($sformatf("vec%0d dataOutL", v), dataOutL, tbl[v].ol);
      check($sformatf("vec%0d flags", v), DW'({dfull, daf}), '0);
    end

    // E and L stream into W: strict alternation, in-order payloads per source
    reset_dut();
    exp_pay  = '{default: 0};
    prev_src = -1;
    for (int c = 0; c < 13; c++) begin
      if (c < 6) step(3'b101, mk(1, 0, c, 1'b1), '0, mk(1, 2, c, 1'b1));
      else       step(3'b000, '0, '0, '0);
      fw = dataOutW;
      if (c >= 1) begin
        check($sformatf("stream valid c%0d", c), DW'(fw[0]), DW'(1));
        if (prev_src >= 0) check($sformatf("stream alternate c%0d", c), DW'(fw[4:3] != prev_src[1:0]), DW'(1));
        check($sformatf("stream order c%0d", c), DW'(fw[DW-1:5]), DW'(exp_pay[fw[4:3]]));
        exp_pay[fw[4:3]]++;
        prev_src = int'(fw[4:3]);
      end
    end

    // E backs up behind L on the W output until full; dropped writes never emerge
    reset_dut();
    af_cyc = -1; full_cyc = -1; dropped_seen = 0;
    dropped = '{default: 1'b0};
    for (int c = 0; c < 30; c++) begin
      if (c < 12) step(3'b101, mk(1, 0, c, 1'b1), '0, mk(1, 2, 0, 1'b1));
      else        step(3'b000, '0, '0, '0);
      if (c < 12 && last_drop[0]) dropped[c] = 1'b1;
      if (af_cyc < 0 && almost_fullE) af_cyc = c;
      if (full_cyc < 0 && fullE) full_cyc = c;
      fw = dataOutW;
      if (fw[0] && fw[4:3] == 2'b00 && dropped[fw[8:5]]) dropped_seen++;
    end
    check("backpressure fullE seen", DW'(full_cyc >= 0), DW'(1));
    check("backpressure af before full", DW'(af_cyc >= 0 && af_cyc < full_cyc), DW'(1));
    check("backpressure dropped flits emitted", DW'(dropped_seen), '0);

    // Reset with flits queued discards them immediately
    reset_dut();
    for (int c = 0; c < 3; c++) step(3'b111, mk(1, 0, c, 1'b1), mk(1, 1, c, 1'b1), mk(1, 2, c, 1'b1));
    writeE = 1'b0; writeW = 1'b0; writeL = 1'b0;
    #2 reset = 1'b1;
    #1;
    model_reset();
    for (int o = 0; o < 3; o++) check($sformatf("midreset dataOut[%0d]", o), dout[o], '0);
    check("midreset full", DW'(dfull), '0);
    check("midreset almost_full", DW'(daf), '0);
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 6; c++) step(3'b000, '0, '0, '0);

    // Random traffic against the model
    for (int c = 0; c < 400; c++) begin
      rw = 3'($urandom_range(0, 7));
      for (int p = 0; p < 3; p++) r[p] = DW'($urandom());
      step(rw, r[0], r[1], r[2]);
    end
    for (int c = 0; c < 12; c++) step(3'b000, '0, '0, '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
